// File: rtl/bitwise_logic_unit_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit: latches operands on start, evaluates one
// SLICE-bit slice per clock (LSB first), then pulses done with a zero flag.
module bitwise_logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       f,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    case (f)
      2'b00:   slice_op = a & b;
      2'b01:   slice_op = a | b;
      2'b10:   slice_op = a ^ b;
      2'b11:   slice_op = ~(a | b);
      default: slice_op = {SLICE{1'b0}};
    endcase
  endfunction

  // Next-state, slice evaluation and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = A;
          b_d      = B;
          op_d     = op;
          result_d = {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            result_d[k*SLICE +: SLICE] = slice_op(op_q, a_q[k*SLICE +: SLICE],
                                                  b_q[k*SLICE +: SLICE]);
          end else begin
            result_d[k*SLICE +: SLICE] = result_q[k*SLICE +: SLICE];
          end
        end
        // Counter parks on the last slice rather than wrapping
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
          zero_d  = (result_d == {WIDTH{1'b0}});
        end else begin
          cnt_d   = cnt_q + CW'(1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 2'b00;
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;

endmodule
